// File: rtl/uart_tx_engine_if.sv
// ============================================================================
// uart_tx_engine_if : LCR, FIFO and serial-line signals of the UART TX engine
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_tx_engine_if;
  logic       baud_pulse;
  logic [1:0] wls;
  logic       stb;
  logic       pen;
  logic       eps;
  logic       sticky_parity;
  logic       set_break;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       temt;

  modport slave (
    input  baud_pulse, wls, stb, pen, eps, sticky_parity, set_break,
    input  fifo_empty, fifo_dout,
    output fifo_pop, tx, tx_busy, temt
  );

  modport master (
    output baud_pulse, wls, stb, pen, eps, sticky_parity, set_break,
    output fifo_empty, fifo_dout,
    input  fifo_pop, tx, tx_busy, temt
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// ============================================================================
// uart_tx_engine : 16550 serial transmitter, 5-8 data bits, parity, 1/1.5/2 stop
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_engine (
  input  logic             clk,
  input  logic             rst,
  uart_tx_engine_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0] state_q,   state_d;
  logic [3:0] tick_q,    tick_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q,   shift_d;
  logic [1:0] wls_q,     wls_d;
  logic       stb_q,     stb_d;
  logic       pen_q,     pen_d;
  logic       eps_q,     eps_d;
  logic       sticky_q,  sticky_d;
  logic       parity_q,  parity_d;
  logic       tx_q,      tx_d;
  logic       tx_busy_q, tx_busy_d;

  logic       w_bit_end;
  logic       w_stop_final;
  logic       w_load;
  logic [7:0] w_word_mask;
  logic       w_data_xor;
  logic       w_new_parity;

  assign w_bit_end = bus.baud_pulse && (tick_q == 4'd15);

  // With two stop bits selected, the second one is cut to half a bit for 5-bit words.
  always_comb begin
    w_stop_final = 1'b0;
    if (state_q == S_STOP && bus.baud_pulse) begin
      if (!stb_q) begin
        w_stop_final = (tick_q == 4'd15);
      end else if (bit_cnt_q[0]) begin
        w_stop_final = (wls_q == 2'b00) ? (tick_q == 4'd7) : (tick_q == 4'd15);
      end
    end
  end

  assign w_load = !bus.fifo_empty &&
                  (((state_q == S_IDLE) && bus.baud_pulse) || w_stop_final);

  always_comb begin
    case (bus.wls)
      2'b00:   w_word_mask = 8'h1F;
      2'b01:   w_word_mask = 8'h3F;
      2'b10:   w_word_mask = 8'h7F;
      default: w_word_mask = 8'hFF;
    endcase
  end

  assign w_data_xor   = ^(bus.fifo_dout & w_word_mask);
  assign w_new_parity = bus.sticky_parity ? ~bus.eps
                                          : (bus.eps ? w_data_xor : ~w_data_xor);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wls_d     = wls_q;
    stb_d     = stb_q;
    pen_d     = pen_q;
    eps_d     = eps_q;
    sticky_d  = sticky_q;
    parity_d  = parity_q;

    if (bus.baud_pulse) begin
      tick_d = tick_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        tick_d    = 4'd0;
        bit_cnt_d = 3'd0;
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (bit_cnt_q == {1'b1, wls_q}) begin
            bit_cnt_d = 3'd0;
            state_d   = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          bit_cnt_d = 3'd0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (w_stop_final) begin
          state_d   = S_IDLE;
          tick_d    = 4'd0;
          bit_cnt_d = 3'd0;
        end else if (w_bit_end) begin
          bit_cnt_d = 3'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        tick_d    = 4'd0;
        bit_cnt_d = 3'd0;
      end
    endcase

    // A load from IDLE or from the last stop strobe overrides the per-state update.
    if (w_load) begin
      state_d   = S_START;
      tick_d    = 4'd0;
      bit_cnt_d = 3'd0;
      shift_d   = bus.fifo_dout;
      wls_d     = bus.wls;
      stb_d     = bus.stb;
      pen_d     = bus.pen;
      eps_d     = bus.eps;
      sticky_d  = bus.sticky_parity;
      parity_d  = w_new_parity;
    end
  end

  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    if (bus.set_break) begin
      tx_d = 1'b0;
    end
    tx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= 4'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      wls_q     <= 2'd0;
      stb_q     <= 1'b0;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      sticky_q  <= 1'b0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wls_q     <= wls_d;
      stb_q     <= stb_d;
      pen_q     <= pen_d;
      eps_q     <= eps_d;
      sticky_q  <= sticky_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
    end
  end

  assign bus.fifo_pop = w_load && !rst;
  assign bus.tx       = tx_q;
  assign bus.tx_busy  = tx_busy_q;
  assign bus.temt     = (state_q == S_IDLE) && bus.fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
// ============================================================================
// tb_uart_tx_engine : directed frame checks for uart_tx_engine with a FIFO model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_engine;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   div;
  int   bcnt;
  int   pop_cnt;
  int   bad_pop;
  int   exp_pops;

  logic [7:0] mem [0:31];
  logic [4:0] rd_ptr;
  logic [4:0] wr_ptr;

  uart_tx_engine_if bus ();

  uart_tx_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.baud_pulse = (bcnt == 0);
  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_dout  = mem[rd_ptr];

  always @(posedge clk) begin
    bcnt <= (bcnt + 1 >= div) ? 0 : bcnt + 1;
    if (bus.fifo_pop) begin
      pop_cnt <= pop_cnt + 1;
      if (rd_ptr == wr_ptr) bad_pop <= bad_pop + 1;
      else                  rd_ptr  <= rd_ptr + 5'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 5'd1;
  endtask

  task automatic cfg(input logic [1:0] w, input logic s, input logic p,
                     input logic e, input logic st);
    bus.wls           = w;
    bus.stb           = s;
    bus.pen           = p;
    bus.eps           = e;
    bus.sticky_parity = st;
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    check({tag, "_tx_idle"}, bus.tx, 1);
    check({tag, "_busy_low"}, bus.tx_busy, 0);
    check({tag, "_temt"}, bus.temt, 1);
    check({tag, "_pops"}, pop_cnt, exp_pops);
  endtask

  // Checks the first and last cycle of every bit; bs/bl place a set_break window.
  task automatic run_frame(input string tag, input logic [7:0] data, input int nbits,
                           input bit has_par, input bit par, input int stop_strobes,
                           input int dv, input int bs, input int bl,
                           input bit scramble, input bit chained);
    logic       seg_val [0:11];
    int         seg_len [0:11];
    int         nseg;
    int         gap;
    int         c;
    logic       e;
    logic [1:0] s_wls;
    logic       s_stb, s_pen, s_eps, s_st;
    bit         last;
    seg_val[0] = 1'b0;
    seg_len[0] = 16 * dv;
    nseg = 1;
    for (int i = 0; i < nbits; i++) begin
      seg_val[nseg] = data[i];
      seg_len[nseg] = 16 * dv;
      nseg++;
    end
    if (has_par) begin
      seg_val[nseg] = par;
      seg_len[nseg] = 16 * dv;
      nseg++;
    end
    seg_val[nseg] = 1'b1;
    seg_len[nseg] = stop_strobes * dv;
    nseg++;
    s_wls = bus.wls; s_stb = bus.stb; s_pen = bus.pen; s_eps = bus.eps; s_st = bus.sticky_parity;

    gap = 0;
    @(negedge clk);
    while (bus.tx !== 1'b0 && gap < 400) begin
      gap++;
      @(negedge clk);
    end
    if (chained) check({tag, "_gap"}, gap, 0);
    else         check({tag, "_started"}, {31'd0, (gap < 400)}, 1);

    c = 0;
    for (int s = 0; s < nseg; s++) begin
      for (int k = 0; k < seg_len[s]; k++) begin
        last = (s == nseg - 1) && (k == seg_len[s] - 1);
        e = (bl > 0 && c - 1 >= bs && c - 1 < bs + bl) ? 1'b0 : seg_val[s];
        if (k == 0 || k == seg_len[s] - 1 ||
            (bl > 0 && (c == bs + 1 || c == bs + bl || c == bs + bl + 1)))
          check($sformatf("%s_seg%0d_cyc%0d", tag, s, c), bus.tx, e);
        bus.set_break = (bl > 0 && c >= bs && c < bs + bl);
        if (scramble && c == 20) cfg(~s_wls, ~s_stb, ~s_pen, ~s_eps, ~s_st);
        if (scramble && last)    cfg(s_wls, s_stb, s_pen, s_eps, s_st);
        c++;
        if (!last) @(negedge clk);
      end
    end
  endtask

  initial begin
    int w;
    checks = 0; errors = 0; div = 1; bcnt = 0;
    pop_cnt = 0; bad_pop = 0; exp_pops = 0;
    rd_ptr = 5'd0; wr_ptr = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    bus.set_break = 1'b0;
    cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", bus.tx, 1);
    check("reset_busy", bus.tx_busy, 0);
    check("reset_temt", bus.temt, 1);
    check("reset_pop", bus.fifo_pop, 0);
    rst = 1'b0;

    // 8N1 0x55
    push(8'h55); exp_pops = 1;
    run_frame("8n1_55", 8'h55, 8, 0, 0, 16, 1, 0, 0, 0, 0);
    post_idle("8n1_55");

    // 7E1 0xB3 -> parity 0, LCR changed mid-frame
    cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'hB3); exp_pops++;
    run_frame("7e1_b3", 8'hB3, 7, 1, 0, 16, 1, 0, 0, 1, 0);
    post_idle("7e1_b3");

    // 8O1 0x01 -> parity 0
    cfg(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    push(8'h01); exp_pops++;
    run_frame("8o1_01", 8'h01, 8, 1, 0, 16, 1, 0, 0, 0, 0);
    post_idle("8o1_01");

    // 7O1 0xB3 -> parity 1
    cfg(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    push(8'hB3); exp_pops++;
    run_frame("7o1_b3", 8'hB3, 7, 1, 1, 16, 1, 0, 0, 0, 0);
    post_idle("7o1_b3");

    // Stick parity: eps=1 -> 0, eps=0 -> 1
    cfg(2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    push(8'h03); exp_pops++;
    run_frame("stick1", 8'h03, 8, 1, 0, 16, 1, 0, 0, 0, 0);
    post_idle("stick1");
    cfg(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    push(8'h00); exp_pops++;
    run_frame("stick0", 8'h00, 8, 1, 1, 16, 1, 0, 0, 0, 0);
    post_idle("stick0");

    // 5-bit, 1.5 stop bits; 6-bit, 2 stop bits
    cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'hFA); exp_pops++;
    run_frame("5n15", 8'hFA, 5, 0, 0, 24, 1, 0, 0, 0, 0);
    post_idle("5n15");
    cfg(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h2D); exp_pops++;
    run_frame("6n2", 8'h2D, 6, 0, 0, 32, 1, 0, 0, 0, 0);
    post_idle("6n2");

    // Back-to-back frames
    cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h00); push(8'hFF); push(8'h0F); exp_pops += 3;
    run_frame("chain0", 8'h00, 8, 0, 0, 16, 1, 0, 0, 0, 0);
    run_frame("chain1", 8'hFF, 8, 0, 0, 16, 1, 0, 0, 0, 1);
    run_frame("chain2", 8'h0F, 8, 0, 0, 16, 1, 0, 0, 0, 1);
    post_idle("chain");

    // Break for 40 clk during data, next frame still on schedule
    push(8'hA5); push(8'h5A); exp_pops += 2;
    run_frame("brk", 8'hA5, 8, 0, 0, 16, 1, 40, 40, 0, 0);
    run_frame("brk_next", 8'h5A, 8, 0, 0, 16, 1, 0, 0, 0, 1);
    post_idle("brk");

    // Reset during the parity bit of a 7E1 frame
    cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'hB3); push(8'h3C); exp_pops++;
    w = 0;
    @(negedge clk);
    while (bus.tx !== 1'b0 && w < 400) begin
      w++;
      @(negedge clk);
    end
    check("rst_started", {31'd0, (w < 400)}, 1);
    repeat (133) @(negedge clk);
    check("rst_parity_bit", bus.tx, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_temt", bus.temt, 0);
    check("rst_pops", pop_cnt, exp_pops);
    rst = 1'b0;
    exp_pops++;
    run_frame("after_rst", 8'h3C, 7, 1, 0, 16, 1, 0, 0, 0, 1);
    post_idle("after_rst");

    // Slower strobe: one strobe every 4 clk
    cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    div = 4;
    push(8'h96); exp_pops++;
    run_frame("div4", 8'h96, 8, 0, 0, 16, 4, 0, 0, 0, 0);
    post_idle("div4");
    div = 1;

    check("no_empty_pop", bad_pop, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
